// File: rtl/seq_read_stage_pkg.sv
// Shared definitions for the read stage: instruction field layout,
// opcode encodings and the read-stage FSM state encodings.
// Optional feature macro used by the stage: READ_STAGE_PERF_CNT_EN.
package seq_read_stage_pkg;

   // Instruction word layout: 16-bit word with the opcode in the top five bits
   localparam int INSTR_SIZE  = 16;
   localparam int OPCODE_SIZE = 5;
   localparam int OPCODE_MSB  = 15;
   localparam int OPCODE_LSB  = 11;

   // Opcodes the read stage and its neighbours care about
   localparam logic [OPCODE_SIZE-1:0] OPCODE_LOAD = 5'h08;
   localparam logic [OPCODE_SIZE-1:0] OPCODE_HALT = 5'h1F;

   // Full NOP instruction word, used for bubbles and as the reset value
   localparam logic [INSTR_SIZE-1:0] INSTR_NOP = 16'h0000;

   // Read-stage FSM state encodings
   localparam logic [1:0] READ_STATE_RUN   = 2'd0;
   localparam logic [1:0] READ_STATE_STALL = 2'd1;
   localparam logic [1:0] READ_STATE_HALT  = 2'd2;

   // Extract the opcode field of an instruction word
   function automatic logic [OPCODE_SIZE-1:0] opcode_of(input logic [INSTR_SIZE-1:0] instruction);
      return instruction[OPCODE_MSB:OPCODE_LSB];
   endfunction

   // True when the instruction stops the program
   function automatic logic is_halt(input logic [INSTR_SIZE-1:0] instruction);
      return opcode_of(instruction) == OPCODE_HALT;
   endfunction

   // True when the instruction reads data memory (used by the load-use logic)
   function automatic logic is_load(input logic [INSTR_SIZE-1:0] instruction);
      return opcode_of(instruction) == OPCODE_LOAD;
   endfunction

endpackage

// File: rtl/seq_read_stage_pipeline_register.sv
// seq_pipeline_register: a width-parameterised pipeline register with a
// synchronous reset value and a load enable; when the enable is low the
// register holds its contents.
// Optional feature macro of the enclosing stage: READ_STAGE_PERF_CNT_EN (not used here).
module seq_pipeline_register #(
   parameter int                   DATA_SIZE   = 32,
   parameter logic [DATA_SIZE-1:0] RESET_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [DATA_SIZE-1:0] d,
   output logic [DATA_SIZE-1:0] q
);

   // Reset wins over enable; otherwise load when enabled, else hold
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VALUE;
      end else if (enable) begin
         q <= d;
      end
   end

endmodule

// File: rtl/seq_read_stage.sv
// seq_read_stage: pipeline register between instruction fetch and execute.
// Captures the fetched instruction together with its already-forwarded
// operands and load-use override flags, inserts bubbles when fetch has
// nothing to offer, holds everything while execute stalls, and parks in a
// terminal halt state once a HALT instruction has been issued.
// Optional feature macro: READ_STAGE_PERF_CNT_EN adds a saturating 16-bit
// bubble counter on o_bubble_count.
module seq_read_stage
   import seq_read_stage_pkg::*;
#(
   parameter int ADDRESS_SIZE = 10,
   parameter int DATA_SIZE    = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [INSTR_SIZE-1:0] i_instruction,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_stall,
   input  logic [DATA_SIZE-1:0]  i_operand1,
   input  logic [DATA_SIZE-1:0]  i_operand2,
   input  logic                  i_read_operand1,
   input  logic                  i_read_operand2,
   output logic [INSTR_SIZE-1:0] o_instruction,
   output logic [DATA_SIZE-1:0]  o_operand1,
   output logic [DATA_SIZE-1:0]  o_operand2,
   output logic                  o_read_operand1,
   output logic                  o_read_operand2,
   output logic                  o_halted
`ifdef READ_STAGE_PERF_CNT_EN
   ,
   output logic [15:0]           o_bubble_count
`endif
);

   // The memory address width only matters to neighbouring blocks; a
   // degenerate value is left without any elaborated logic.
   if (ADDRESS_SIZE < 1) begin : g_invalid_address_size
   end

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic                  in_halt;
   logic                  issue;
   logic                  load_enable;
   logic [INSTR_SIZE-1:0] instruction_d;
   logic [DATA_SIZE-1:0]  operand1_d;
   logic [DATA_SIZE-1:0]  operand2_d;
   logic                  read_operand1_d;
   logic                  read_operand2_d;

   assign in_halt     = (state == READ_STATE_HALT);
   assign issue       = !in_halt && i_valid;
   assign load_enable = !i_stall;

   // Fetch may hand over an instruction only when execute is not stalling,
   // the program has not halted and the stage is out of reset.
   assign o_ready = !i_stall && !in_halt && !i_rst;

   // Select the payload for the pipeline registers: a real instruction when
   // one is issued, otherwise a NOP bubble with cleared operands and flags
   always_comb begin
      instruction_d   = INSTR_NOP;
      operand1_d      = '0;
      operand2_d      = '0;
      read_operand1_d = 1'b0;
      read_operand2_d = 1'b0;
      if (issue) begin
         instruction_d   = i_instruction;
         operand1_d      = i_operand1;
         operand2_d      = i_operand2;
         read_operand1_d = i_read_operand1;
         read_operand2_d = i_read_operand2;
      end
   end

   // Next-state logic: halt is terminal, a stall parks in STALL, an issued
   // HALT instruction enters HALT, anything else runs
   always_comb begin
      state_next = state;
      if (in_halt) begin
         state_next = READ_STATE_HALT;
      end else if (i_stall) begin
         state_next = READ_STATE_STALL;
      end else if (issue && is_halt(i_instruction)) begin
         state_next = READ_STATE_HALT;
      end else begin
         state_next = READ_STATE_RUN;
      end
   end

   // State register; reset always returns to RUN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= READ_STATE_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Halted flag rises one edge after the HALT instruction reached execute
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_halted <= 1'b0;
      end else if (in_halt) begin
         o_halted <= 1'b1;
      end
   end

   seq_pipeline_register #(
      .DATA_SIZE   (INSTR_SIZE),
      .RESET_VALUE (INSTR_NOP)
   ) u_instruction_reg (
      .clk    (i_clk),
      .rst    (i_rst),
      .enable (load_enable),
      .d      (instruction_d),
      .q      (o_instruction)
   );

   seq_pipeline_register #(
      .DATA_SIZE   (DATA_SIZE),
      .RESET_VALUE ('0)
   ) u_operand1_reg (
      .clk    (i_clk),
      .rst    (i_rst),
      .enable (load_enable),
      .d      (operand1_d),
      .q      (o_operand1)
   );

   seq_pipeline_register #(
      .DATA_SIZE   (DATA_SIZE),
      .RESET_VALUE ('0)
   ) u_operand2_reg (
      .clk    (i_clk),
      .rst    (i_rst),
      .enable (load_enable),
      .d      (operand2_d),
      .q      (o_operand2)
   );

   seq_pipeline_register #(
      .DATA_SIZE   (1),
      .RESET_VALUE (1'b0)
   ) u_read_operand1_reg (
      .clk    (i_clk),
      .rst    (i_rst),
      .enable (load_enable),
      .d      (read_operand1_d),
      .q      (o_read_operand1)
   );

   seq_pipeline_register #(
      .DATA_SIZE   (1),
      .RESET_VALUE (1'b0)
   ) u_read_operand2_reg (
      .clk    (i_clk),
      .rst    (i_rst),
      .enable (load_enable),
      .d      (read_operand2_d),
      .q      (o_read_operand2)
   );

`ifdef READ_STAGE_PERF_CNT_EN
   logic bubble_insert;

   assign bubble_insert = load_enable && !issue;

   // Count every edge that pushes a bubble to execute, saturating at all ones
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_bubble_count <= '0;
      end else if (bubble_insert && (o_bubble_count != 16'hFFFF)) begin
         o_bubble_count <= o_bubble_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_read_stage.sv
// Self-checking bench for seq_read_stage: directed steps from the test plan
// followed by randomized traffic, all checked against a transaction-level
// reference model of the stage.
// Honours READ_STAGE_PERF_CNT_EN when it is defined.
module tb_seq_read_stage;
   import seq_read_stage_pkg::*;

   localparam int DATA_SIZE = 32;
   localparam logic [4:0] OP_ADD = 5'h01;

   logic                 i_clk = 1'b0;
   logic                 i_rst;
   logic [15:0]          i_instruction;
   logic                 i_valid;
   logic                 o_ready;
   logic                 i_stall;
   logic [DATA_SIZE-1:0] i_operand1;
   logic [DATA_SIZE-1:0] i_operand2;
   logic                 i_read_operand1;
   logic                 i_read_operand2;
   logic [15:0]          o_instruction;
   logic [DATA_SIZE-1:0] o_operand1;
   logic [DATA_SIZE-1:0] o_operand2;
   logic                 o_read_operand1;
   logic                 o_read_operand2;
   logic                 o_halted;
`ifdef READ_STAGE_PERF_CNT_EN
   logic [15:0]          o_bubble_count;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: what execute should currently be seeing
   logic [15:0]          m_instruction = 16'h0000;
   logic [DATA_SIZE-1:0] m_operand1 = '0;
   logic [DATA_SIZE-1:0] m_operand2 = '0;
   logic                 m_read1 = 1'b0;
   logic                 m_read2 = 1'b0;
   logic                 m_halt_issued = 1'b0;
   logic                 m_halted = 1'b0;
   int                   m_bubbles = 0;

   seq_read_stage #(
      .ADDRESS_SIZE (10),
      .DATA_SIZE    (DATA_SIZE)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_instruction   (i_instruction),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_stall         (i_stall),
      .i_operand1      (i_operand1),
      .i_operand2      (i_operand2),
      .i_read_operand1 (i_read_operand1),
      .i_read_operand2 (i_read_operand2),
      .o_instruction   (o_instruction),
      .o_operand1      (o_operand1),
      .o_operand2      (o_operand2),
      .o_read_operand1 (o_read_operand1),
      .o_read_operand2 (o_read_operand2),
      .o_halted        (o_halted)
`ifdef READ_STAGE_PERF_CNT_EN
      ,
      .o_bubble_count  (o_bubble_count)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 i_clk = ~i_clk;

   // One comparison: counts it and reports a failure through the assertion
   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance the model by one rising edge using the inputs now applied
   task automatic modelStep();
      if (i_rst) begin
         m_instruction = 16'h0000;
         m_operand1    = '0;
         m_operand2    = '0;
         m_read1       = 1'b0;
         m_read2       = 1'b0;
         m_halt_issued = 1'b0;
         m_halted      = 1'b0;
         m_bubbles     = 0;
      end else begin
         if (m_halt_issued) m_halted = 1'b1;
         if (!i_stall) begin
            if (!m_halt_issued && i_valid) begin
               m_instruction = i_instruction;
               m_operand1    = i_operand1;
               m_operand2    = i_operand2;
               m_read1       = i_read_operand1;
               m_read2       = i_read_operand2;
               if (i_instruction[15:11] == OPCODE_HALT) m_halt_issued = 1'b1;
            end else begin
               m_instruction = 16'h0000;
               m_operand1    = '0;
               m_operand2    = '0;
               m_read1       = 1'b0;
               m_read2       = 1'b0;
               if (m_bubbles < 65535) m_bubbles++;
            end
         end
      end
   endtask

   // Compare every registered output with the model
   task automatic checkOutput();
      check("instruction", {16'h0, o_instruction}, {16'h0, m_instruction});
      check("operand1", o_operand1, m_operand1);
      check("operand2", o_operand2, m_operand2);
      check("read_operand1", {31'h0, o_read_operand1}, {31'h0, m_read1});
      check("read_operand2", {31'h0, o_read_operand2}, {31'h0, m_read2});
      check("halted", {31'h0, o_halted}, {31'h0, m_halted});
`ifdef READ_STAGE_PERF_CNT_EN
      check("bubble_count", {16'h0, o_bubble_count}, m_bubbles);
`endif
   endtask

   // Drive one cycle of inputs, check the combinational ready, clock it in
   // and check the registered outputs shortly after the edge
   task automatic applyStimulus(input logic rst_value, input logic valid_value,
                                input logic [15:0] instr_value,
                                input logic [31:0] op1_value, input logic [31:0] op2_value,
                                input logic read1_value, input logic read2_value,
                                input logic stall_value);
      logic expected_ready;
      @(negedge i_clk);
      i_rst           = rst_value;
      i_valid         = valid_value;
      i_instruction   = instr_value;
      i_operand1      = op1_value;
      i_operand2      = op2_value;
      i_read_operand1 = read1_value;
      i_read_operand2 = read2_value;
      i_stall         = stall_value;
      #1;
      expected_ready = !stall_value && !m_halt_issued && !rst_value;
      check("ready", {31'h0, o_ready}, {31'h0, expected_ready});
      @(posedge i_clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   // Directed test-plan steps followed by randomized traffic
   initial begin
      logic [15:0] add_instr;
      logic [15:0] load_instr;
      logic [15:0] halt_instr;
      logic [15:0] rnd_instr;
      add_instr  = {OP_ADD, 11'h012};
      load_instr = {OPCODE_LOAD, 11'h034};
      halt_instr = {OPCODE_HALT, 11'h000};

      // Reset
      applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, add_instr, 32'h5, 32'h6, 1, 1, 0);

      // ADD with operands 11/22, then three bubbles
      applyStimulus(0, 1, add_instr, 32'h11, 32'h22, 0, 0, 0);
      applyStimulus(0, 0, add_instr, 32'h33, 32'h44, 1, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0);

      // Load-use instruction held through a two-cycle stall while inputs change
      applyStimulus(0, 1, load_instr, 32'hAAAA, 32'hBBBB, 1, 0, 0);
      applyStimulus(0, 1, add_instr, 32'h1, 32'h2, 0, 1, 1);
      applyStimulus(0, 1, add_instr, 32'h3, 32'h4, 0, 0, 1);
      applyStimulus(0, 1, add_instr, 32'h7, 32'h8, 0, 1, 0);

      // Reset in the middle of a stall with an ADD held
      applyStimulus(0, 1, add_instr, 32'h11, 32'h22, 0, 0, 0);
      applyStimulus(0, 1, add_instr, 32'h99, 32'h98, 0, 0, 1);
      applyStimulus(1, 1, add_instr, 32'h99, 32'h98, 0, 0, 1);
      applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0);

      // HALT together with a stall, released next cycle; later inputs ignored
      applyStimulus(0, 1, halt_instr, 32'h1, 32'h2, 0, 0, 1);
      applyStimulus(0, 1, halt_instr, 32'h1, 32'h2, 0, 0, 0);
      applyStimulus(0, 1, add_instr, 32'h5, 32'h6, 1, 1, 0);
      applyStimulus(0, 1, add_instr, 32'h5, 32'h6, 1, 1, 1);
      applyStimulus(0, 1, add_instr, 32'h5, 32'h6, 1, 1, 0);

      // Reset out of HALT, then back-to-back HALTs
      applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, halt_instr, 32'hC, 32'hD, 0, 0, 0);
      applyStimulus(0, 1, halt_instr, 32'hE, 32'hF, 0, 0, 0);
      applyStimulus(0, 1, add_instr, 32'h1, 32'h1, 0, 0, 0);
      applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 0);

      // Randomized traffic with occasional HALTs and resets
      for (int i = 0; i < 600; i++) begin
         rnd_instr = 16'($urandom);
         if ($urandom_range(0, 15) == 0) rnd_instr[15:11] = OPCODE_HALT;
         else if (rnd_instr[15:11] == OPCODE_HALT) rnd_instr[15:11] = OP_ADD;
         applyStimulus(($urandom_range(0, 29) == 0) || (i % 97 == 96),
                       $urandom_range(0, 3) != 0,
                       rnd_instr, $urandom, $urandom,
                       1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
